// File: rtl/count_stream_checker.sv
// Receive-side checker for the counting stream: accepts beats under a selectable
// backpressure pattern and verifies each frame is 0..up_to with last on the final beat.
module count_stream_checker #(
  parameter int          DATA_WIDTH = 32,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  counter_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] count_up_to,
  input  logic [1:0]            ready_mode,
  input  logic                  halt_on_error,
  input  logic                  err_clear,
  input  logic [DATA_WIDTH-1:0] count_up,
  input  logic                  count_valid,
  input  logic                  count_last,
  output logic                  count_ready,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  data_err,
  output logic                  last_err,
  output logic [DATA_WIDTH-1:0] last_value,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [DATA_WIDTH-1:0] ONE_D   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  ONE_C   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [1:0]            r_state;
  logic                  r_ready;
  logic                  r_alt;
  logic [15:0]           r_lfsr;
  logic [DATA_WIDTH-1:0] r_expected;
  logic [DATA_WIDTH-1:0] r_up_to;
  logic                  r_frame_done;
  logic [CNT_WIDTH-1:0]  r_frame_count;
  logic [CNT_WIDTH-1:0]  r_err_count;
  logic                  r_data_err;
  logic                  r_last_err;
  logic [DATA_WIDTH-1:0] r_last_value;

  logic                  w_xfer;
  logic                  w_data_ok;
  logic                  w_last_ok;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_exp_nxt;
  logic [15:0]           w_lfsr_nxt;
  logic [1:0]            w_state_nxt;
  logic                  w_pattern;
  logic                  w_ready_nxt;

  // A beat transfers on a rising edge where count_valid && count_ready; the source
  // holds data stable until then, and ready never depends combinationally on valid.
  always_comb begin
    w_xfer     = count_valid && r_ready;
    w_data_ok  = (count_up == r_expected);
    w_last_ok  = (count_last == (r_expected == r_up_to));
    w_err      = w_xfer && !(w_data_ok && w_last_ok);
    w_exp_nxt  = r_expected;
    if (w_xfer) w_exp_nxt = count_last ? '0 : count_up + ONE_D;
    w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  end

  // Leaving RECV only at a frame boundary keeps partial frames out of IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (enable) w_state_nxt = S_RECV;
      S_RECV: begin
        if (w_err && halt_on_error)        w_state_nxt = S_HOLD;
        else if (!enable && w_exp_nxt == '0) w_state_nxt = S_IDLE;
      end
      S_HOLD: if (err_clear) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pattern = 1'b0;
    case (ready_mode)
      2'b00:   w_pattern = 1'b1;
      2'b01:   w_pattern = 1'b0;
      2'b10:   w_pattern = r_alt;
      default: w_pattern = w_lfsr_nxt[0];
    endcase
    // Ready rises one cycle after RECV entry and drops on the edge that leaves RECV.
    w_ready_nxt = (r_state == S_RECV) && (w_state_nxt == S_RECV) && w_pattern;
  end

  always_ff @(posedge counter_clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b0;
      r_alt         <= 1'b1;
      r_lfsr        <= LFSR_SEED;
      r_expected    <= '0;
      r_up_to       <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_err_count   <= '0;
      r_data_err    <= 1'b0;
      r_last_err    <= 1'b0;
      r_last_value  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ready      <= w_ready_nxt;
      r_lfsr       <= w_lfsr_nxt;
      r_alt        <= (r_state == S_RECV) ? ~r_alt : 1'b1;
      r_frame_done <= 1'b0;
      if (err_clear) begin
        r_data_err <= 1'b0;
        r_last_err <= 1'b0;
      end
      if (r_state == S_IDLE && enable) begin
        r_up_to    <= count_up_to;
        r_expected <= '0;
      end
      if (r_state == S_HOLD && err_clear) r_expected <= '0;
      // Error flags are assigned after the clear so a same-cycle error wins.
      if (w_xfer) begin
        r_expected   <= w_exp_nxt;
        r_last_value <= count_up;
        if (!w_data_ok) r_data_err <= 1'b1;
        if (!w_last_ok) r_last_err <= 1'b1;
        if (w_err && r_err_count != CNT_MAX) r_err_count <= r_err_count + ONE_C;
        if (count_last) begin
          r_up_to      <= count_up_to;
          r_frame_done <= 1'b1;
          if (r_frame_count != CNT_MAX) r_frame_count <= r_frame_count + ONE_C;
        end
      end
    end
  end

  assign count_ready = r_ready;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign err_count   = r_err_count;
  assign data_err    = r_data_err;
  assign last_err    = r_last_err;
  assign last_value  = r_last_value;
  assign dbg_state   = r_state;

endmodule

// File: doc/count_stream_checker.md
# count_stream_checker

Receive-side endpoint for the counting stream produced by `streamer_up`: a valid/ready sink that accepts beats of `count_up`, drives `count_ready` with a selectable backpressure pattern, and checks each frame against the expected sequence 0, 1, …, `count_up_to`, with last asserted on the final beat. It sits at the far end of the counter stream, in the Axis_Mux test fabric. It reports frame completions, data and last-flag errors, and the last accepted value.

## Interface
- `DATA_WIDTH`, 32: stream data width and `count_up_to` width.
- `CNT_WIDTH`, 16: width of the frame and error counters (saturating).
- `LFSR_SEED`, 16'hACE1: reset seed of the random-ready LFSR; must be nonzero.

Ports:
- `counter_clk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  1 = leave IDLE and accept beats.
- `count_up_to`  in  DATA_WIDTH  terminal value of a frame; latched at frame start.
- `ready_mode`  in  2  backpressure pattern: 00 always, 01 never, 10 alternate, 11 LFSR.
- `halt_on_error`  in  1  1 = enter HOLD on the first error.
- `err_clear`  in  1  clears sticky flags, leaves HOLD, restarts the frame.
- `count_up`  in  DATA_WIDTH  stream data.
- `count_valid`  in  1  stream valid.
- `count_last`  in  1  stream last.
- `count_ready`  out  1  stream ready; registered.
- `frame_done`  out  1  one-cycle pulse after a frame's last beat is accepted.
- `frame_count`  out  CNT_WIDTH  frames completed (saturating).
- `err_count`  out  CNT_WIDTH  beats with any mismatch (saturating).
- `data_err`  out  1  sticky: an accepted data value differed from the expected value.
- `last_err`  out  1  sticky: last was asserted or omitted incorrectly.
- `last_value`  out  DATA_WIDTH  data of the most recent accepted beat.

## Operation
- A transfer occurs on a rising edge where `count_valid && count_ready`. Only transfers update the checker state.
- State machine states:
  - IDLE: `count_ready` = 0. Goes to RECV when `enable` = 1; `count_up_to` is latched into `up_to_q` and `expected` = 0.
  - RECV: `count_ready` follows the `ready_mode` pattern.
    - Goes to IDLE when `enable` = 0 at a frame boundary (`expected` = 0).
    - Goes to HOLD on an erroneous transfer when `halt_on_error` = 1.
  - HOLD: `count_ready` = 0. Goes to IDLE on `err_clear`.
- Check per transfer:
  - `data_ok` = (`count_up` == `expected`).
  - `last_ok` = (`count_last` == (`expected` == `up_to_q`)).
  - A failure sets the corresponding sticky flag and increments `err_count` once per beat, even if both checks fail.
- Expected update after a transfer:
  - If `count_last` = 1: `expected` = 0, `up_to_q` reloads from `count_up_to`, `frame_count` increments, `frame_done` pulses.
  - Otherwise `expected` = `count_up` + 1, modulo 2^DATA_WIDTH. This resynchronizes the checker to the incoming data after an error.
- Ready patterns:
  - 10: toggles every cycle while in RECV, starting at 1.
  - 11: `count_ready` = `lfsr[0]`. The LFSR is a 16-bit Fibonacci LFSR with taps 16,14,13,11, advancing every cycle.
  - A mode change takes effect on the next cycle.
- `err_clear` in any state clears `data_err` and `last_err`. Counters are unaffected.

## Timing
- Reset values:
  - `count_ready`, `frame_done`, `data_err`, `last_err` = 0.
  - `frame_count`, `err_count`, `last_value` = 0.
  - state = IDLE, `expected` = 0, lfsr = `LFSR_SEED`.
- `count_ready` is a registered output: rises the cycle after the entry into RECV.
- Updates become visible on the cycle after the accepting edge: `last_value`, flags, counters, and `frame_done`.
- `count_up_to` = 0: every frame is a single beat with value 0 and last = 1.
- `count_up_to` = 2^DATA_WIDTH−1: `expected` wraps to 0 only via last.
- A `count_up_to` change mid-frame is ignored until the next frame.
- At saturation (all ones), counters hold their value.
- Simultaneous `err_clear` and an erroneous transfer: the flag is set (the error wins). `err_count` still increments.
- Reset mid-frame: everything returns to its reset values on that edge, and the partial frame is discarded.
- A transfer coinciding with the entry into HOLD is still checked and counted. There are no transfers in HOLD.

## Test plan
- Always-ready (`ready_mode`=00), `count_up_to`=20, clean `streamer_up` source → 21 beats 0..20, `frame_done` after value 20, `frame_count`=1, `err_count`=0.
- `ready_mode`=10, `count_up_to`=5, three frames → `count_ready` alternates, `frame_count`=3, no errors, `last_value`=5.
- Inject data 7 where 6 is expected, with `halt_on_error`=0 → `data_err`=1, `err_count`=1; next beat 8 is accepted without error.
- Last on value 3 with `count_up_to`=5 and `halt_on_error`=1 → `last_err`=1, state HOLD, `count_ready`=0; after `err_clear`, IDLE then RECV resumes with `expected`=0.
- `ready_mode`=11, `count_up_to`=0, 50 frames → every beat is 0 with last, `frame_count`=50, ready matches the LFSR sequence from seed 16'hACE1.
- Assert `reset` mid-frame at value 10 → next cycle all outputs at reset values; a new frame 0..20 then passes cleanly.
